// File: rtl/bless_inject_eject_stage.sv
// BLESS inject/eject stage: registers four link flits, ejects one local flit, injects one FIFO flit, ages flits, computes PPVs.
// Optional EJECT_OLDEST_EN: eject the oldest local candidate instead of the lowest-index one.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef VALID_POS
`define VALID_POS 31
`endif
`ifndef TIME_POS
`define TIME_POS 30:23
`endif
`ifndef TIME_WIDTH
`define TIME_WIDTH 8
`endif
`ifndef DST_X_POS
`define DST_X_POS 7:4
`endif
`ifndef DST_Y_POS
`define DST_Y_POS 3:0
`endif
`ifndef COORD_WIDTH
`define COORD_WIDTH 4
`endif
`ifndef NUM_PORT
`define NUM_PORT 5
`endif

module bless_inject_eject_stage #(
   parameter logic [`COORD_WIDTH-1:0] X_COORD   = '0,
   parameter logic [`COORD_WIDTH-1:0] Y_COORD   = '0,
   parameter int unsigned             INJ_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [`DATA_WIDTH-1:0] in0,
   input  logic [`DATA_WIDTH-1:0] in1,
   input  logic [`DATA_WIDTH-1:0] in2,
   input  logic [`DATA_WIDTH-1:0] in3,
   input  logic [`DATA_WIDTH-1:0] inj_data,
   input  logic                   inj_valid,
   output logic                   inj_ready,
   output logic [`DATA_WIDTH-1:0] eject_data,
   output logic                   eject_valid,
   output logic [`DATA_WIDTH-1:0] data0,
   output logic [`DATA_WIDTH-1:0] data1,
   output logic [`DATA_WIDTH-1:0] data2,
   output logic [`DATA_WIDTH-1:0] data3,
   output logic [`NUM_PORT-1:0]   ppv0,
   output logic [`NUM_PORT-1:0]   ppv1,
   output logic [`NUM_PORT-1:0]   ppv2,
   output logic [`NUM_PORT-1:0]   ppv3
);

   localparam int unsigned PW = $clog2(INJ_DEPTH);

   typedef logic [`DATA_WIDTH-1:0] flit_t;
   typedef logic [`NUM_PORT-1:0]   ppv_t;

   function automatic ppv_t f_ppv(input flit_t f);
      ppv_t p;
      p = '0;
      if (f[`VALID_POS]) begin
         p[0] = f[`DST_Y_POS] > Y_COORD;
         p[2] = f[`DST_Y_POS] < Y_COORD;
         p[1] = f[`DST_X_POS] > X_COORD;
         p[3] = f[`DST_X_POS] < X_COORD;
         p[4] = (f[`DST_X_POS] == X_COORD) && (f[`DST_Y_POS] == Y_COORD);
      end
      return p;
   endfunction

   flit_t             w_in [4];
   logic  [3:0]       w_cand;
   logic  [3:0]       w_free;
   logic  [1:0]       w_win;
   logic              w_win_vld;
   logic  [1:0]       w_inj_slot;
   logic              w_pop;
   logic              w_push;
   logic              w_full;
   flit_t             w_head;
   flit_t             w_next [4];

   flit_t             r_data [4];
   ppv_t              r_ppv  [4];
   flit_t             r_ej_data;
   logic              r_ej_vld;
   flit_t             r_mem  [INJ_DEPTH];
   logic  [PW-1:0]    r_wr_ptr;
   logic  [PW-1:0]    r_rd_ptr;
   logic  [PW:0]      r_count;

   assign w_in[0] = in0;
   assign w_in[1] = in1;
   assign w_in[2] = in2;
   assign w_in[3] = in3;

   assign w_full = (r_count == (PW+1)'(INJ_DEPTH));
   assign w_head = r_mem[r_rd_ptr];
   assign w_push = inj_valid && !w_full;

   always_comb begin
      w_cand    = '0;
      w_win     = '0;
      w_win_vld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         w_cand[i] = w_in[i][`VALID_POS] && (w_in[i][`DST_X_POS] == X_COORD)
                     && (w_in[i][`DST_Y_POS] == Y_COORD);
      end
      for (int i = 0; i < 4; i++) begin
`ifdef EJECT_OLDEST_EN
         // strict compare keeps the lowest index on equal ages
         if (w_cand[i] && (!w_win_vld || (w_in[i][`TIME_POS] > w_in[w_win][`TIME_POS]))) begin
`else
         if (w_cand[i] && !w_win_vld) begin
`endif
            w_win     = 2'(i);
            w_win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      w_free     = '0;
      w_inj_slot = '0;
      for (int i = 0; i < 4; i++) begin
         w_free[i] = !w_in[i][`VALID_POS] || (w_win_vld && (w_win == 2'(i)));
      end
      for (int i = 3; i >= 0; i--) begin
         if (w_free[i]) w_inj_slot = 2'(i);
      end
      w_pop = (r_count != '0) && (|w_free);
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_next[i] = w_in[i];
         if (w_pop && (w_inj_slot == 2'(i))) begin
            w_next[i]             = w_head;
            w_next[i][`TIME_POS]  = '0;
            w_next[i][`VALID_POS] = 1'b1;
         end else if (w_free[i]) begin
            w_next[i] = '0;
         end else if (!(&w_in[i][`TIME_POS])) begin
            w_next[i][`TIME_POS] = w_in[i][`TIME_POS] + `TIME_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            r_data[i] <= '0;
            r_ppv[i]  <= '0;
         end
         r_ej_data <= '0;
         r_ej_vld  <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            r_data[i] <= w_next[i];
            r_ppv[i]  <= f_ppv(w_next[i]);
         end
         r_ej_data <= w_win_vld ? w_in[w_win] : '0;
         r_ej_vld  <= w_win_vld;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < INJ_DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= inj_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign inj_ready   = !w_full;
   assign eject_data  = r_ej_data;
   assign eject_valid = r_ej_vld;
   assign data0       = r_data[0];
   assign data1       = r_data[1];
   assign data2       = r_data[2];
   assign data3       = r_data[3];
   assign ppv0        = r_ppv[0];
   assign ppv1        = r_ppv[1];
   assign ppv2        = r_ppv[2];
   assign ppv3        = r_ppv[3];

endmodule

// File: tb/tb_bless_inject_eject_stage.sv
// Self-checking bench for bless_inject_eject_stage at router (1,1) against a queue-based reference model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef VALID_POS
`define VALID_POS 31
`endif
`ifndef TIME_POS
`define TIME_POS 30:23
`endif
`ifndef TIME_WIDTH
`define TIME_WIDTH 8
`endif
`ifndef DST_X_POS
`define DST_X_POS 7:4
`endif
`ifndef DST_Y_POS
`define DST_Y_POS 3:0
`endif
`ifndef COORD_WIDTH
`define COORD_WIDTH 4
`endif
`ifndef NUM_PORT
`define NUM_PORT 5
`endif

module tb_bless_inject_eject_stage;
   localparam int DEPTH = 4;
   localparam int RX = 1;
   localparam int RY = 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] in_d [4];
   logic [31:0] inj_data = '0;
   logic        inj_valid = 1'b0;
   logic        inj_ready;
   logic [31:0] eject_data;
   logic        eject_valid;
   logic [31:0] o_data [4];
   logic [4:0]  o_ppv [4];

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mq [$];
   logic [31:0] exp_data [4];
   logic [4:0]  exp_ppv [4];
   logic [31:0] exp_ej;
   logic        exp_ev;
   logic        exp_rdy;

   always #5 clk = ~clk;

   bless_inject_eject_stage #(.X_COORD(4'(RX)), .Y_COORD(4'(RY)), .INJ_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .in0(in_d[0]), .in1(in_d[1]), .in2(in_d[2]), .in3(in_d[3]),
      .inj_data(inj_data), .inj_valid(inj_valid), .inj_ready(inj_ready),
      .eject_data(eject_data), .eject_valid(eject_valid),
      .data0(o_data[0]), .data1(o_data[1]), .data2(o_data[2]), .data3(o_data[3]),
      .ppv0(o_ppv[0]), .ppv1(o_ppv[1]), .ppv2(o_ppv[2]), .ppv3(o_ppv[3])
   );

   function automatic logic [31:0] mk(input bit v, input int age, input int dx, input int dy);
      logic [31:0] f;
      f = {1'b0, 8'(age), 15'($urandom), 4'(dx), 4'(dy)};
      f[31] = v;
      return f;
   endfunction

   function automatic logic [31:0] rnd_flit();
      return mk($urandom_range(3, 0) != 0, $urandom_range(255, 0),
                $urandom_range(3, 0), $urandom_range(3, 0));
   endfunction

   function automatic bit is_local(input logic [31:0] f);
      return f[31] && int'(f[7:4]) == RX && int'(f[3:0]) == RY;
   endfunction

   // Routing from destination arithmetic: N=0 E=1 S=2 W=3 Local=4.
   function automatic logic [4:0] ref_ppv(input logic [31:0] f);
      int dx, dy;
      if (!f[31]) return 5'b0;
      dx = int'(f[7:4]) - RX;
      dy = int'(f[3:0]) - RY;
      if (dx == 0 && dy == 0) return 5'b10000;
      return {1'b0, dx < 0, dy < 0, dx > 0, dy > 0};
   endfunction

   task automatic model_step();
      int win, slot, age;
      bit freed [4];
      win = -1;
      for (int i = 0; i < 4; i++) begin
         if (is_local(in_d[i])) begin
`ifdef EJECT_OLDEST_EN
            if (win < 0 || int'(in_d[i][30:23]) > int'(in_d[win][30:23])) win = i;
`else
            if (win < 0) win = i;
`endif
         end
      end
      exp_ev = (win >= 0);
      exp_ej = (win >= 0) ? in_d[win] : 32'h0;
      for (int i = 0; i < 4; i++) freed[i] = !in_d[i][31] || (i == win);
      slot = -1;
      if (mq.size() > 0)
         for (int i = 3; i >= 0; i--) if (freed[i]) slot = i;
      for (int i = 0; i < 4; i++) begin
         if (i == slot) begin
            exp_data[i] = mq[0];
            exp_data[i][30:23] = 8'd0;
            exp_data[i][31] = 1'b1;
         end else if (freed[i]) begin
            exp_data[i] = 32'h0;
         end else begin
            exp_data[i] = in_d[i];
            age = int'(in_d[i][30:23]) + 1;
            exp_data[i][30:23] = (age > 255) ? 8'd255 : 8'(age);
         end
         exp_ppv[i] = ref_ppv(exp_data[i]);
      end
      begin
         bit accept;
         accept = inj_valid && (mq.size() < DEPTH);
         if (slot >= 0) void'(mq.pop_front());
         if (accept) mq.push_back(inj_data);
      end
      exp_rdy = (mq.size() < DEPTH);
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      for (int i = 0; i < 4; i++) in_d[i] = 32'h0;
      inj_valid = 1'b0;
      inj_data  = 32'h0;
   endtask

   task automatic set_all_busy();
      for (int i = 0; i < 4; i++) in_d[i] = mk(1, $urandom_range(100, 0), 3, 0);
   endtask

   task automatic test_reset();
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < 4; i++) in_d[i] = rnd_flit();
         inj_valid = 1'b1;
         inj_data  = rnd_flit();
         cycle();
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (eject_valid !== 1'b0 || inj_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_flags: eject_valid=%b inj_ready=%b want 0/1", eject_valid, inj_ready);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (o_data[i] !== 32'h0 || o_ppv[i] !== 5'h0) begin
            n_bad++;
            $display("FAIL reset_slot%0d: data=%h ppv=%b want 0", i, o_data[i], o_ppv[i]);
         end
      end
      mq.delete();
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      in_d[0] = mk(1, 3, 2, 2);
      in_d[1] = mk(1, 4, 0, 1);
      in_d[2] = 32'h0;
      in_d[3] = mk(1, 1, 1, 0);
      inj_valid = 1'b0;
      #1;
      n_cmp++;
      if (o_data[0] !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_early: data0=%h want 0 before the edge", o_data[0]);
      end
      cycle();
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (o_data[i] !== exp_data[i] || o_ppv[i] !== exp_ppv[i]) begin
            n_bad++;
            $display("FAIL reset_first slot%0d: data=%h ppv=%b want %h %b", i, o_data[i], o_ppv[i], exp_data[i], exp_ppv[i]);
         end
      end
   endtask

   task automatic test_route();
      set_idle();
      in_d[1] = mk(1, 5, 3, 1);
      in_d[2] = mk(1, 7, 0, 2);
      cycle();
      n_cmp++;
      if (o_data[1][30:23] !== 8'd6 || o_ppv[1] !== 5'b00010) begin
         n_bad++;
         $display("FAIL route_in1: age=%0d ppv=%b want 6 00010", o_data[1][30:23], o_ppv[1]);
      end
      n_cmp++;
      if (o_data[2][30:23] !== 8'd8 || o_ppv[2] !== 5'b01001) begin
         n_bad++;
         $display("FAIL route_in2: age=%0d ppv=%b want 8 01001", o_data[2][30:23], o_ppv[2]);
      end
   endtask

   task automatic test_eject();
      logic [31:0] f0, f3;
      set_idle();
      f0 = mk(1, 9, 1, 1);
      f3 = mk(1, 12, 1, 1);
      in_d[0] = f0;
      in_d[3] = f3;
      cycle();
`ifdef EJECT_OLDEST_EN
      n_cmp++;
      if (eject_valid !== 1'b1 || eject_data !== f3) begin
         n_bad++;
         $display("FAIL eject_win: valid=%b data=%h want 1 %h", eject_valid, eject_data, f3);
      end
      n_cmp++;
      if (o_data[3][31] !== 1'b0 || o_ppv[0] !== 5'b10000 || o_data[0][31] !== 1'b1) begin
         n_bad++;
         $display("FAIL eject_slots: v3=%b ppv0=%b v0=%b want 0 10000 1", o_data[3][31], o_ppv[0], o_data[0][31]);
      end
`else
      n_cmp++;
      if (eject_valid !== 1'b1 || eject_data !== f0) begin
         n_bad++;
         $display("FAIL eject_win: valid=%b data=%h want 1 %h", eject_valid, eject_data, f0);
      end
      n_cmp++;
      if (o_data[0][31] !== 1'b0 || o_ppv[3] !== 5'b10000 || o_data[3][31] !== 1'b1) begin
         n_bad++;
         $display("FAIL eject_slots: v0=%b ppv3=%b v3=%b want 0 10000 1", o_data[0][31], o_ppv[3], o_data[3][31]);
      end
`endif
   endtask

   task automatic drain();
      set_idle();
      for (int c = 0; c < 8 && mq.size() > 0; c++) cycle();
      n_cmp++;
      if (mq.size() != 0 || inj_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL drain: model_left=%0d inj_ready=%b want 0 1", mq.size(), inj_ready);
      end
   endtask

   task automatic test_inject_blocked();
      logic [31:0] f;
      drain();
      set_all_busy();
      f = mk(0, 77, 0, 3);
      inj_data = f;
      inj_valid = 1'b1;
      cycle();
      inj_valid = 1'b0;
      set_all_busy();
      cycle();
      n_cmp++;
      if (o_data[2] !== exp_data[2] || o_data[2][30:23] === 8'd0) begin
         n_bad++;
         $display("FAIL inj_blocked: data2=%h want %h (no injection)", o_data[2], exp_data[2]);
      end
      set_all_busy();
      in_d[2] = 32'h0;
      cycle();
      n_cmp++;
      if (o_data[2][31] !== 1'b1 || o_data[2][30:23] !== 8'd0 || o_data[2][22:0] !== f[22:0]) begin
         n_bad++;
         $display("FAIL inj_slot2: data2=%h want payload %h age 0 valid 1", o_data[2], f[22:0]);
      end
      in_d[2] = 32'h0;
      cycle();
      n_cmp++;
      if (o_data[2][31] !== 1'b0) begin
         n_bad++;
         $display("FAIL inj_empty: data2 valid=%b want 0", o_data[2][31]);
      end
   endtask

   task automatic test_fifo_full();
      logic [31:0] first;
      drain();
      for (int k = 0; k < 5; k++) begin
         set_all_busy();
         inj_data = mk(1, 50 + k, 2, 0);
         if (k == 0) first = inj_data;
         inj_valid = 1'b1;
         cycle();
         n_cmp++;
         if (inj_ready !== ((k >= 3) ? 1'b0 : 1'b1)) begin
            n_bad++;
            $display("FAIL full_ready push%0d: inj_ready=%b want %b", k, inj_ready, (k >= 3) ? 1'b0 : 1'b1);
         end
      end
      set_all_busy();
      in_d[2] = 32'h0;
      inj_valid = 1'b0;
      cycle();
      n_cmp++;
      if (inj_ready !== 1'b1 || o_data[2][22:0] !== first[22:0] || o_data[2][31] !== 1'b1) begin
         n_bad++;
         $display("FAIL full_pop: inj_ready=%b data2=%h want 1 payload %h", inj_ready, o_data[2], first[22:0]);
      end
      set_idle();
      for (int k = 0; k < 4; k++) begin
         cycle();
         n_cmp++;
         if (o_data[0][31] !== exp_data[0][31] || (exp_data[0][31] && o_data[0] !== exp_data[0])) begin
            n_bad++;
            $display("FAIL full_drain%0d: data0=%h want %h", k, o_data[0], exp_data[0]);
         end
      end
   endtask

   task automatic test_age_sat();
      set_idle();
      in_d[0] = mk(1, 255, 0, 0);
      in_d[1] = mk(1, 254, 2, 2);
      cycle();
      n_cmp++;
      if (o_data[0][30:23] !== 8'hFF || o_data[1][30:23] !== 8'hFF) begin
         n_bad++;
         $display("FAIL age_sat: age0=%h age1=%h want ff ff", o_data[0][30:23], o_data[1][30:23]);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++) in_d[i] = rnd_flit();
         inj_valid = ($urandom_range(1, 0) == 1);
         inj_data  = rnd_flit();
         cycle();
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (o_data[i][31] !== exp_data[i][31] || (exp_data[i][31] && o_data[i] !== exp_data[i])
                || o_ppv[i] !== exp_ppv[i]) begin
               n_bad++;
               $display("FAIL rand c%0d slot%0d: data=%h ppv=%b want %h %b", c, i, o_data[i], o_ppv[i], exp_data[i], exp_ppv[i]);
            end
         end
         n_cmp++;
         if (eject_valid !== exp_ev || (exp_ev && eject_data !== exp_ej) || inj_ready !== exp_rdy) begin
            n_bad++;
            $display("FAIL rand c%0d eject/ready: ev=%b ed=%h rdy=%b want %b %h %b", c, eject_valid, eject_data, inj_ready, exp_ev, exp_ej, exp_rdy);
         end
      end
   endtask

   initial begin
      set_idle();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      reset_n = 1'b1;
      #1;
      test_reset();
      test_route();
      test_eject();
      test_inject_blocked();
      test_fifo_full();
      test_age_sat();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
